// File: rtl/wrapper_pkg.sv
// Shared constants, types and AHB encodings for the accelerator wrapper.
package wrapper_pkg;

    localparam int REGDWIDTH     = 32;
    localparam int REGDBYTEWIDTH = 2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } reader_state_t;

    // Number of byte-address bits needed to span one packet.
    function automatic int packet_byte_width(input int packet_width);
        return $clog2(packet_width / 8);
    endfunction

    // Number of 32-bit register words in one packet.
    function automatic int num_words(input int packet_width);
        return packet_width / REGDWIDTH;
    endfunction

endpackage

// File: rtl/wrapper_word_mux.sv
// Selects one 32-bit word out of a packet-wide vector; word 0 is the LSBs.
module wrapper_word_mux
    import wrapper_pkg::*;
#(
    parameter int PACKETWIDTH = 512,
    localparam int IDXW       = $clog2(PACKETWIDTH / REGDWIDTH)
) (
    input  logic [PACKETWIDTH-1:0] data_in,
    input  logic [IDXW-1:0]        word_idx,
    output logic [REGDWIDTH-1:0]   word_out
);

    // Word k occupies bits [32k+31 : 32k].
    always_comb begin
        word_out = data_in[{word_idx, 5'b00000} +: REGDWIDTH];
    end

endmodule

// File: rtl/wrapper_packet_reader.sv
// Holds one packet from the accelerator deconstructor and presents it to the
// AHB master as 32-bit read words. The buffer is released only once the
// last word of the packet has been read; a status word reports full/last.
module wrapper_packet_reader
    import wrapper_pkg::*;
#(
    parameter int ADDRWIDTH   = 11,
    parameter int PACKETWIDTH = 512
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   hsels,
    input  logic [ADDRWIDTH-1:0]   haddrs,
    input  logic [1:0]             htranss,
    input  logic                   hwrites,
    input  logic                   hreadys,
    output logic [REGDWIDTH-1:0]   hrdatas,
    output logic                   hreadyouts,
    output logic                   hresps,
    input  logic [PACKETWIDTH-1:0] packet_data,
    input  logic                   packet_data_last,
    input  logic                   packet_data_valid,
    output logic                   packet_data_ready,
    output logic                   data_avail
);

    localparam int PBW      = packet_byte_width(PACKETWIDTH);
    localparam int NUMWORDS = num_words(PACKETWIDTH);
    localparam int IDXW     = PBW - REGDBYTEWIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMWORDS - 1);

    reader_state_t            state_q, state_d;
    logic                     release_pending_q, release_pending_d;
    logic                     last_flag_q, last_flag_d;
    logic                     rd_active_q, rd_active_d;
    logic                     rd_sel_q, rd_sel_d;
    logic [IDXW-1:0]          rd_idx_q, rd_idx_d;
    logic [PACKETWIDTH-1:0]   buf_q, buf_d;

    logic                     trans_req;
    logic                     win_sel;
    logic [IDXW-1:0]          addr_idx;
    logic                     win_req_last;
    logic                     capture;
    logic [REGDWIDTH-1:0]     buf_word;

    // Upper address bits alias and the byte offset is ignored.
    generate
        if (ADDRWIDTH > PBW + 1) begin : g_alias
            logic unused_addr;
            assign unused_addr = ^{haddrs[ADDRWIDTH-1:PBW+1], haddrs[1:0]};
        end else begin : g_no_alias
            logic unused_addr;
            assign unused_addr = ^haddrs[1:0];
        end
    endgenerate

    // Address-phase decode of an AHB read request.
    always_comb begin
        trans_req    = hsels & hreadys & ~hwrites &
                       ((htranss == HTRANS_NONSEQ) | (htranss == HTRANS_SEQ));
        win_sel      = ~haddrs[PBW];
        addr_idx     = haddrs[PBW-1:REGDBYTEWIDTH];
        win_req_last = trans_req & win_sel & (addr_idx == LAST_IDX);
    end

    // Next-state logic for the buffer FSM and the read-data selectors.
    always_comb begin
        state_d           = state_q;
        release_pending_d = release_pending_q;
        last_flag_d       = last_flag_q;
        rd_active_d       = rd_active_q;
        rd_sel_d          = rd_sel_q;
        rd_idx_d          = rd_idx_q;
        capture           = 1'b0;

        if (hreadys) begin
            rd_active_d = trans_req;
        end
        if (trans_req) begin
            rd_sel_d = ~win_sel;
            rd_idx_d = addr_idx;
        end

        case (state_q)
            EMPTY: begin
                if (packet_data_valid) begin
                    capture     = 1'b1;
                    last_flag_d = packet_data_last;
                    state_d     = FULL;
                end
            end
            FULL: begin
                // Release waits for the last-word data phase to complete.
                if (release_pending_q && hreadys) begin
                    release_pending_d = 1'b0;
                    state_d           = EMPTY;
                end else if (win_req_last) begin
                    release_pending_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase

        buf_d = capture ? packet_data : buf_q;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q           <= EMPTY;
            release_pending_q <= 1'b0;
            last_flag_q       <= 1'b0;
            rd_active_q       <= 1'b0;
            rd_sel_q          <= 1'b0;
            rd_idx_q          <= '0;
        end else begin
            state_q           <= state_d;
            release_pending_q <= release_pending_d;
            last_flag_q       <= last_flag_d;
            rd_active_q       <= rd_active_d;
            rd_sel_q          <= rd_sel_d;
            rd_idx_q          <= rd_idx_d;
        end
    end

    // Packet storage; contents are never visible while EMPTY, so no reset.
    always_ff @(posedge hclk) begin
        buf_q <= buf_d;
    end

    wrapper_word_mux #(
        .PACKETWIDTH (PACKETWIDTH)
    ) u_word_mux (
        .data_in  (buf_q),
        .word_idx (rd_idx_q),
        .word_out (buf_word)
    );

    // Data-phase read mux and handshake outputs.
    always_comb begin
        hrdatas = '0;
        if (rd_active_q) begin
            if (rd_sel_q) begin
                hrdatas = {30'b0, last_flag_q, (state_q == FULL)};
            end else if (state_q == FULL) begin
                hrdatas = buf_word;
            end
        end
        hreadyouts        = 1'b1;
        hresps            = 1'b0;
        packet_data_ready = (state_q == EMPTY);
        data_avail        = (state_q == FULL) & ~(win_req_last | release_pending_q);
    end

endmodule

// File: tb/tb_wrapper_packet_reader.sv
// Directed bench for wrapper_packet_reader (ADDRWIDTH=11, PACKETWIDTH=512).
module tb_wrapper_packet_reader;

    logic         hclk;
    logic         hresetn;
    logic         hsels;
    logic [10:0]  haddrs;
    logic [1:0]   htranss;
    logic         hwrites;
    logic         hreadys;
    logic [31:0]  hrdatas;
    logic         hreadyouts;
    logic         hresps;
    logic [511:0] packet_data;
    logic         packet_data_last;
    logic         packet_data_valid;
    logic         packet_data_ready;
    logic         data_avail;

    int n_cmp = 0;
    int n_bad = 0;

    wrapper_packet_reader #(
        .ADDRWIDTH   (11),
        .PACKETWIDTH (512)
    ) dut (
        .hclk              (hclk),
        .hresetn           (hresetn),
        .hsels             (hsels),
        .haddrs            (haddrs),
        .htranss           (htranss),
        .hwrites           (hwrites),
        .hreadys           (hreadys),
        .hrdatas           (hrdatas),
        .hreadyouts        (hreadyouts),
        .hresps            (hresps),
        .packet_data       (packet_data),
        .packet_data_last  (packet_data_last),
        .packet_data_valid (packet_data_valid),
        .packet_data_ready (packet_data_ready),
        .data_avail        (data_avail)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [511:0] mk(input logic [31:0] base);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsels   = 1'b0;
        htranss = 2'b00;
        hwrites = 1'b0;
        haddrs  = '0;
    endtask

    task automatic addr_phase(input logic [10:0] a, input logic w);
        hsels   = 1'b1;
        htranss = 2'b10;
        haddrs  = a;
        hwrites = w;
    endtask

    // One read: address phase, then data phase with the bus idle.
    task automatic do_read(input logic [10:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        step();
        bus_idle();
        #3;
        d = hrdatas;
        step();
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        #2;
        n_cmp++; if (data_avail !== 1'b0) begin n_bad++; $display("FAIL rst_avail: got %b expected 0", data_avail); end
        n_cmp++; if (packet_data_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", packet_data_ready); end
        n_cmp++; if (hrdatas !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 00000000", hrdatas); end
        n_cmp++; if (hreadyouts !== 1'b1) begin n_bad++; $display("FAIL rst_hreadyout: got %b expected 1", hreadyouts); end
        n_cmp++; if (hresps !== 1'b0) begin n_bad++; $display("FAIL rst_hresp: got %b expected 0", hresps); end
        step();
        step();
        hresetn = 1'b1;
        step();
        n_cmp++; if (data_avail !== 1'b0 || packet_data_ready !== 1'b1 || hrdatas !== 32'h0) begin
            n_bad++; $display("FAIL idle_after_rst: got avail=%b ready=%b rdata=%h expected 0/1/0", data_avail, packet_data_ready, hrdatas);
        end
    endtask

    task automatic test_load_read();
        logic [31:0] d;
        packet_data       = mk(32'hA000_0000);
        packet_data_last  = 1'b1;
        packet_data_valid = 1'b1;
        #3;
        n_cmp++; if (data_avail !== 1'b0) begin n_bad++; $display("FAIL avail_before_cap: got %b expected 0", data_avail); end
        n_cmp++; if (packet_data_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before_cap: got %b expected 1", packet_data_ready); end
        step();
        packet_data_valid = 1'b0;
        n_cmp++; if (data_avail !== 1'b1) begin n_bad++; $display("FAIL avail_rise: got %b expected 1", data_avail); end
        n_cmp++; if (packet_data_ready !== 1'b0) begin n_bad++; $display("FAIL ready_full: got %b expected 0", packet_data_ready); end
        for (int k = 0; k < 15; k++) begin
            do_read(11'(k * 4), d);
            n_cmp++; if (d !== 32'hA000_0000 + 32'(k)) begin n_bad++; $display("FAIL word_read[%0d]: got %h expected %h", k, d, 32'hA000_0000 + 32'(k)); end
        end
        do_read(11'h040, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL status_full_last: got %h expected 00000003", d); end
        n_cmp++; if (data_avail !== 1'b1) begin n_bad++; $display("FAIL status_no_release: got %b expected 1", data_avail); end
        do_read(11'h00C, d);
        n_cmp++; if (d !== 32'hA000_0003) begin n_bad++; $display("FAIL repeat_read: got %h expected A0000003", d); end
        do_read(11'h404, d);
        n_cmp++; if (d !== 32'hA000_0001) begin n_bad++; $display("FAIL alias_read: got %h expected A0000001", d); end
        n_cmp++; if (data_avail !== 1'b1) begin n_bad++; $display("FAIL avail_after_partial: got %b expected 1", data_avail); end
    endtask

    task automatic test_last_read();
        logic [31:0] d;
        addr_phase(11'h03C, 1'b0);
        #3;
        n_cmp++; if (data_avail !== 1'b0) begin n_bad++; $display("FAIL avail_drop_addr: got %b expected 0", data_avail); end
        step();
        bus_idle();
        #3;
        n_cmp++; if (hrdatas !== 32'hA000_000F) begin n_bad++; $display("FAIL last_word: got %h expected A000000F", hrdatas); end
        n_cmp++; if (packet_data_ready !== 1'b0 || data_avail !== 1'b0) begin n_bad++; $display("FAIL data_phase_hold: got ready=%b avail=%b expected 0/0", packet_data_ready, data_avail); end
        step();
        n_cmp++; if (packet_data_ready !== 1'b1) begin n_bad++; $display("FAIL released: got %b expected 1", packet_data_ready); end
        do_read(11'h000, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL empty_window: got %h expected 00000000", d); end
        do_read(11'h03C, d);
        n_cmp++; if (d !== 32'h0 || packet_data_ready !== 1'b1 || data_avail !== 1'b0) begin
            n_bad++; $display("FAIL empty_last_read: got rdata=%h ready=%b avail=%b expected 0/1/0", d, packet_data_ready, data_avail);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        packet_data       = mk(32'hB000_0000);
        packet_data_last  = 1'b0;
        packet_data_valid = 1'b1;
        step();
        packet_data_valid = 1'b0;
        do_read(11'h040, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL status_full_notlast: got %h expected 00000001", d); end
        addr_phase(11'h03C, 1'b0);
        step();
        bus_idle();
        hreadys = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++; if (data_avail !== 1'b0 || packet_data_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got avail=%b ready=%b expected 0/0", i, data_avail, packet_data_ready);
            end
            step();
        end
        hreadys = 1'b1;
        #3;
        n_cmp++; if (hrdatas !== 32'hB000_000F) begin n_bad++; $display("FAIL stall_last_word: got %h expected B000000F", hrdatas); end
        step();
        n_cmp++; if (packet_data_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b expected 1", packet_data_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          cnt;
        packet_data       = mk(32'hC000_0000);
        packet_data_last  = 1'b0;
        packet_data_valid = 1'b1;
        for (int p = 0; p < 3; p++) begin
            cnt = 0;
            while (data_avail !== 1'b1 && cnt < 5) begin
                step();
                cnt++;
            end
            n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL b2b_capture_latency[%0d]: got %0d expected 1", p, cnt); end
            packet_data = mk(32'hC000_0000 + 32'((p + 1) << 8));
            do_read(11'h000, d);
            n_cmp++; if (d !== 32'hC000_0000 + 32'(p << 8)) begin n_bad++; $display("FAIL b2b_word0[%0d]: got %h expected %h", p, d, 32'hC000_0000 + 32'(p << 8)); end
            do_read(11'h03C, d);
            n_cmp++; if (d !== 32'hC000_000F + 32'(p << 8)) begin n_bad++; $display("FAIL b2b_word15[%0d]: got %h expected %h", p, d, 32'hC000_000F + 32'(p << 8)); end
            n_cmp++; if (packet_data_ready !== 1'b1 || data_avail !== 1'b0) begin
                n_bad++; $display("FAIL b2b_idle_cycle[%0d]: got ready=%b avail=%b expected 1/0", p, packet_data_ready, data_avail);
            end
        end
        packet_data_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        packet_data       = mk(32'hD000_0000);
        packet_data_valid = 1'b1;
        step();
        packet_data_valid = 1'b0;
        addr_phase(11'h03C, 1'b0);
        step();
        bus_idle();
        hreadys = 1'b0;
        #1;
        hresetn = 1'b0;
        #1;
        n_cmp++; if (data_avail !== 1'b0 || packet_data_ready !== 1'b1 || hrdatas !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got avail=%b ready=%b rdata=%h expected 0/1/0", data_avail, packet_data_ready, hrdatas);
        end
        step();
        hresetn = 1'b1;
        hreadys = 1'b1;
        step();
        do_read(11'h004, d);
        n_cmp++; if (d !== 32'h0 || data_avail !== 1'b0) begin n_bad++; $display("FAIL after_mid_reset: got rdata=%h avail=%b expected 0/0", d, data_avail); end
    endtask

    task automatic test_write_ignored();
        logic [31:0] d;
        packet_data       = mk(32'hE000_0000);
        packet_data_valid = 1'b1;
        step();
        packet_data_valid = 1'b0;
        addr_phase(11'h03C, 1'b1);
        #3;
        n_cmp++; if (data_avail !== 1'b1) begin n_bad++; $display("FAIL write_addr_avail: got %b expected 1", data_avail); end
        step();
        bus_idle();
        #3;
        n_cmp++; if (data_avail !== 1'b1 || packet_data_ready !== 1'b0) begin n_bad++; $display("FAIL write_no_release: got avail=%b ready=%b expected 1/0", data_avail, packet_data_ready); end
        step();
        do_read(11'h014, d);
        n_cmp++; if (d !== 32'hE000_0005) begin n_bad++; $display("FAIL write_data_intact: got %h expected E0000005", d); end
        do_read(11'h03C, d);
        n_cmp++; if (d !== 32'hE000_000F || packet_data_ready !== 1'b1) begin n_bad++; $display("FAIL write_final_release: got rdata=%h ready=%b expected E000000F/1", d, packet_data_ready); end
    endtask

    initial begin
        hresetn           = 1'b0;
        hreadys           = 1'b1;
        packet_data       = '0;
        packet_data_last  = 1'b0;
        packet_data_valid = 1'b0;
        bus_idle();
        test_reset();
        test_load_read();
        test_last_read();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_write_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wrapper_packet_reader.md
Name: wrapper_packet_reader

Overview:
- Read-side counterpart of the wrapper's write data-request logic.
- Accepts one PACKETWIDTH-bit output packet from the accelerator deconstructor via a valid/ready handshake and holds it.
- Exposes the held packet to the AHB master as 32-bit read words.
- Raises data_avail while a packet is held, drops it at the address phase of the last-word read, and releases the buffer when that read's data phase completes.

Parameters:
- ADDRWIDTH, 11, AHB slave address width. Must be > PACKETBYTEWIDTH.
- PACKETWIDTH, 512, packet width in bits. Power of two, ≥ 64.

Ports:
- hclk  input  1  clock
- hresetn  input  1  reset
- hsels  input  1  AHB slave select
- haddrs  input  ADDRWIDTH  AHB address
- htranss  input  2  AHB transfer type
- hwrites  input  1  AHB write flag
- hreadys  input  1  AHB bus ready
- hrdatas  output  32  AHB read data
- hreadyouts  output  1  slave ready; tied 1
- hresps  output  1  slave response; tied 0 (OKAY)
- packet_data  input  PACKETWIDTH  packet from deconstructor
- packet_data_last  input  1  packet is last of a stream
- packet_data_valid  input  1  packet valid
- packet_data_ready  output  1  buffer can accept a packet
- data_avail  output  1  packet available to read (read-side data request)

Interface decision: one clock, hclk; reset hresetn is asynchronous and active-low.

Behaviour:
- Derived constants:
  - PACKETBYTEWIDTH = clog2(PACKETWIDTH/8)
  - REGDBYTEWIDTH = 2
  - NUMWORDS = PACKETWIDTH/32
- trans_req = hsels & hreadys & htranss[1] & ~hwrites. Writes are accepted with OKAY and ignored.
- Address decode:
  - haddrs[PACKETBYTEWIDTH] = 0: packet window. Word index = haddrs[PACKETBYTEWIDTH-1:2]; word 0 = packet_data[31:0].
  - haddrs[PACKETBYTEWIDTH] = 1: status word = {30'b0, last_flag, full}.
  - Higher address bits are ignored (aliasing).
- FSM states, encoding 1 bit:
  - EMPTY: packet_data_ready = 1. On packet_data_valid, capture packet_data and packet_data_last into last_flag; go to FULL next edge.
  - FULL: packet_data_ready = 0. A packet-window trans_req at word NUMWORDS-1 sets release_pending (registered). The next cycle with hreadys=1 and release_pending=1 clears release_pending and moves to EMPTY.
- Read data path:
  - Address phase registers rd_sel (window/status) and rd_idx on trans_req.
  - Data phase drives hrdatas combinationally from the buffer or status using the registered selectors. Zero wait states.
  - hrdatas = 0 when no read data phase is active.
  - Packet-window reads in EMPTY return 32'h0.
  - Status reads never cause a release.
- data_avail (combinational):
  - 0 in EMPTY.
  - In FULL: 0 if (window trans_req at last word) or release_pending; else 1.
  - Rises the cycle after capture.
- Out-of-order or partial reads are legal. Only a last-word read releases. Repeated non-last reads return the same data.
- Release and reload: packet_data_ready is registered state, so there is at least one idle cycle between release and the next capture. No capture happens in the release cycle.
- Last-word read in EMPTY: no effect. release_pending is only set in FULL.
- Reset: async clear of state=EMPTY, release_pending=0, last_flag=0, rd_sel/rd_idx=0.
  - Outputs after reset: data_avail=0, packet_data_ready=1, hrdatas=0, hreadyouts=1, hresps=0.
  - Buffer contents are not reset; they are unobservable while EMPTY.
  - A reset mid-packet discards the packet.

Decomposition:
- Package wrapper_pkg:
  - REGDWIDTH=32.
  - Functions/constants for PACKETBYTEWIDTH, REGDBYTEWIDTH, NUMWORDS.
  - Enum reader_state_t {EMPTY, FULL}.
  - AHB HTRANS encodings.
- Optional sub-module wrapper_word_mux: parameterised PACKETWIDTH→32 word selector, reusable by the write side. Everything else stays in one module.

Test Plan:
- Reset then idle → data_avail=0, packet_data_ready=1, hrdatas=0, hreadyouts=1, hresps=0.
- Load packet word k = 32'hA000_0000+k with last=1 → data_avail rises 1 cycle after valid&ready. Reads of 0x00..0x38 return A000_0000..A000_000E. Status read (0x40) returns 32'h3.
- Read 0x3C (last word) → data_avail=0 in that address-phase cycle. Data phase returns A000_000F. state=EMPTY after the data-phase edge. packet_data_ready=1 next cycle.
- Last-word address phase with hreadys held 0 for 3 data-phase cycles (another slave stalls) → data_avail stays 0 and the packet is held until hreadys=1, then released.
- packet_data_valid held high continuously with back-to-back last-word reads → each packet captured exactly once, one idle cycle between release and capture, no word lost or duplicated.
- Assert hresetn low while FULL and release_pending=1 → immediate data_avail=0, packet_data_ready=1. Window reads return 0. Write to 0x3C in FULL → no release, data_avail stays 1.
